// File: rtl/tri_feeder.sv
// tri_feeder: stages vertices, issues them to the triangle
// engine, and captures its pixel stream into an 8x8 framebuffer.
module tri_feeder #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vin_valid,
  output logic        vin_ready,
  input  logic [5:0]  vin_data,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic        tri_done,
  output logic        tri_err,
  output logic [6:0]  tri_pix,
  output logic [15:0] total_pix,
  input  logic        fb_clr,
  input  logic [5:0]  rd_addr,
  output logic        rd_data
);

  typedef enum logic [2:0] {
    IDLE, ISSUE1, ISSUE2, ISSUE3, WAIT_BUSY, WAIT_DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [5:0]  stage [3];
  logic [1:0]  cnt;
  logic [5:0]  v2, v3;
  logic [7:0]  to_cnt;
  logic [6:0]  tri_cnt, tri_cnt_inc;
  logic [63:0] fb, fb_nxt;
  logic        accept, start, finish, timeout;
  logic        nt_d;
  logic [5:0]  vx_d;

  assign vin_ready = (cnt != 2'd3);
  assign accept    = vin_valid & vin_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the events that ride on each transition.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (cnt == 2'd3 && !busy) begin
          state_nxt = ISSUE1;
          start     = 1'b1;
        end
      end
      ISSUE1: state_nxt = ISSUE2;
      ISSUE2: state_nxt = ISSUE3;
      ISSUE3: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine-side outputs, decoded from the state being entered.
  always_comb begin
    nt_d = 1'b0;
    vx_d = 6'd0;
    case (state_nxt)
      ISSUE1: begin
        nt_d = 1'b1;
        vx_d = stage[0];
      end
      ISSUE2:  vx_d = v2;
      ISSUE3:  vx_d = v3;
      default: vx_d = 6'd0;
    endcase
  end

  // Pixel bookkeeping: saturating count and clear-then-set write.
  always_comb begin
    tri_cnt_inc = tri_cnt;
    if (po && tri_cnt != 7'd64) tri_cnt_inc = tri_cnt + 7'd1;
    fb_nxt = fb_clr ? 64'd0 : fb;
    if (po) fb_nxt[{yo, xo}] = 1'b1;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) stage[i] <= 6'd0;
      cnt       <= 2'd0;
      v2        <= 6'd0;
      v3        <= 6'd0;
      to_cnt    <= 8'd0;
      tri_cnt   <= 7'd0;
      tri_pix   <= 7'd0;
      total_pix <= 16'd0;
      tri_done  <= 1'b0;
      tri_err   <= 1'b0;
      fb        <= 64'd0;
      rd_data   <= 1'b0;
      nt        <= 1'b0;
      xi        <= 3'd0;
      yi        <= 3'd0;
    end else begin
      if (start) begin
        v2  <= stage[1];
        v3  <= stage[2];
        cnt <= 2'd0;
      end else if (accept) begin
        stage[cnt] <= vin_data;
        cnt        <= cnt + 2'd1;
      end
      if (state == ISSUE3)
        to_cnt <= 8'd0;
      else if (state == WAIT_BUSY && !busy)
        to_cnt <= to_cnt + 8'd1;
      tri_cnt <= start ? 7'd0 : tri_cnt_inc;
      if (finish | timeout) tri_pix <= tri_cnt_inc;
      tri_done <= finish | timeout;
      tri_err  <= timeout;
      if (po && total_pix != 16'hFFFF)
        total_pix <= total_pix + 16'd1;
      fb      <= fb_nxt;
      rd_data <= fb[rd_addr];
      nt      <= nt_d;
      xi      <= vx_d[5:3];
      yi      <= vx_d[2:0];
    end
  end

endmodule

// File: doc/tri_feeder.md
# tri_feeder

Host-side driver for the triangle rendering engine (`triangle`). It accepts vertices from an upstream valid/ready stream and buffers three of them. When the engine is not busy, it issues them on the engine's `nt`/`xi`/`yi` protocol. It then collects the engine's `po`/`xo`/`yo` pixel stream into an 8x8 one-bit framebuffer with per-triangle and total pixel counts.

## Interface

Parameters:
- BUSY_TIMEOUT, 4: cycles to wait in WAIT_BUSY for the engine to raise `busy` before abandoning the triangle.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vin_valid  in  1  upstream vertex valid.
- vin_ready  out  1  upstream vertex ready.
- vin_data  in  6  vertex, {x[2:0], y[2:0]}.
- nt  out  1  new-triangle strobe to engine.
- xi  out  3  vertex x to engine.
- yi  out  3  vertex y to engine.
- busy  in  1  engine busy.
- po  in  1  engine pixel valid.
- xo  in  3  engine pixel x.
- yo  in  3  engine pixel y.
- tri_done  out  1  one-cycle pulse when a triangle completes or times out.
- tri_err  out  1  valid with `tri_done`; 1 means timeout.
- tri_pix  out  7  pixels received for the last triangle (0..64); held until the next `tri_done`.
- total_pix  out  16  pixels received since reset; saturates at 0xFFFF.
- fb_clr  in  1  clear the framebuffer.
- rd_addr  in  6  framebuffer read index, {y, x}.
- rd_data  out  1  framebuffer bit; registered.

## Operation

- **Staging buffer:** 3 entries plus `cnt` (0..3).
  - `vin_ready = (cnt != 3)`. It is combinational from `cnt` and is independent of state.
  - A vertex is accepted when `vin_valid & vin_ready`. It is written to `stage[cnt]` and `cnt` increments.
- **States:** IDLE, ISSUE1, ISSUE2, ISSUE3, WAIT_BUSY, WAIT_DONE.
- **IDLE:** if `cnt == 3 && !busy`, go to ISSUE1. On that edge, copy `stage[0..2]` to issue registers `v1..v3`, set `cnt` to 0, and clear the triangle pixel counter. Upstream may then refill staging while the current triangle is in flight.
- **ISSUE1:** `nt=1`, `{xi,yi}=v1`. Go to ISSUE2.
- **ISSUE2:** `nt=0`, `{xi,yi}=v2`. Go to ISSUE3.
- **ISSUE3:** `nt=0`, `{xi,yi}=v3`. Go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY:**
  - If `busy`, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT, go to IDLE with a `tri_done=1`, `tri_err=1` pulse.
- **WAIT_DONE:** when `busy` is sampled 0, go to IDLE with a `tri_done=1`, `tri_err=0` pulse.
- **Outside ISSUE states:** `nt=0` and `xi=yi=0`. The block never tristates.
- **Pixel capture (any state, including ISSUE):** on `po=1`:
  - set `fb[{yo,xo}]`;
  - increment the triangle counter, saturating at 64;
  - increment `total_pix`, saturating.
- **Pixel counter report:** `tri_pix` loads the triangle counter on the `tri_done` edge. A `po` sampled on that same edge is included.
- **fb_clr:** clears all 64 bits on the next edge. If `po` is sampled on the same edge, that pixel's bit is set after the clear, so the write wins.
- **Readout:** `rd_data` = `fb[rd_addr]` sampled on the previous edge (1-cycle latency). It reflects framebuffer contents before the same-edge update.

## Timing

- **Reset values:** state IDLE, `cnt`=0, `vin_ready`=1, `nt`=0, `xi`=`yi`=0, `tri_done`=0, `tri_err`=0, `tri_pix`=0, `total_pix`=0, `fb`=0, `rd_data`=0.
- **Output registration:** `nt`, `xi`, `yi`, `tri_done`, `tri_err`, `tri_pix`, `rd_data` are all registered.
- **Issue latency:** edge E samples `cnt==3 && !busy` in IDLE. `nt=1` with v1 is driven during cycle E+1, v2 during E+2, v3 during E+3. The engine samples each vertex at the end of its cycle.
- **Back-to-back triangles:** `busy` is sampled low at edge K in WAIT_DONE. `tri_done` is high during cycle K+1. If staging is full, `nt` rises again during cycle K+2.
- **Simultaneous events:**
  - A vertex accepted on the IDLE→ISSUE1 edge is impossible, because `cnt==3` forces `vin_ready=0`.
  - A vertex accepted in any other state lands in staging.
- **Reset mid-operation:** reset aborts immediately and returns every output and register to its reset value. Staged vertices are discarded.

## Test plan

- **Reset:** assert `reset` 2 cycles mid-issue -> next cycle `nt`=0, `xi`=`yi`=0, `vin_ready`=1, `total_pix`=0, reading `rd_addr`=0..63 returns all 0.
- **Single triangle:** feed 0x0A, 0x0E, 0x1E with `busy`=0 -> `nt`=1 and `{xi,yi}`=(1,2), then (1,6), then (3,6) on consecutive cycles. Engine model raises `busy` 1 cycle later and emits 5 `po` pixels including (2,3), then drops `busy` -> `tri_done`=1, `tri_err`=0, `tri_pix`=5, `total_pix`=5. Reading `rd_addr`=0x1A gives 1; reading 0x00 gives 0.
- **Backpressure:** present 4 vertices back-to-back with `busy`=1 held -> first 3 accepted, `vin_ready`=0 on the 4th, no `nt`. Release `busy` -> issue starts and `vin_ready` returns to 1 the cycle after the copy.
- **Preload:** load a second triangle during WAIT_DONE -> its `nt` pulse occurs exactly 2 cycles after `busy` is sampled low, and `tri_pix` for it counts only its own pixels.
- **Timeout:** never raise `busy` after issue -> `tri_done`=1 and `tri_err`=1 during the cycle after BUSY_TIMEOUT (4) WAIT_BUSY cycles; state returns to IDLE.
- **Clear collision:** `fb_clr`=1 with `po`=1 at (7,7) on the same edge -> `fb[63]`=1 and every other bit 0; 70 pixels on one triangle -> `tri_pix`=64.
